// File: rtl/wb_io_arb_pkg.sv
// -----------------------------------------------------------------------------
// wb_io_arb_pkg
// Shared definitions for the two-master IO Wishbone arbiter:
//   - arb_state_e   : arbitration FSM encoding (IDLE / OWN0 / OWN1). The
//                     encoding is one-hot in the owner bits, so a state value
//                     reads directly as a {m1,m0} grant vector.
//   - CTI_*         : Wishbone cycle-type identifiers used by the masters
//   - wd_cnt_width  : width of the watchdog counter for a given timeout
// -----------------------------------------------------------------------------
package wb_io_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN0 = 2'b01,
    ST_OWN1 = 2'b10
  } arb_state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // The counter has to hold values 0..TIMEOUT_CYCLES.
  function automatic int unsigned wd_cnt_width(input int unsigned timeout_cycles);
    return $clog2(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/wb_io_arbiter_if.sv
// -----------------------------------------------------------------------------
// wb_io_arbiter_if
// One Wishbone B4 link (request + response signals).
//   master modport : the side that issues cycles (drives adr..bte)
//   slave  modport : the side that answers (drives dat_r/ack/err/rty)
// Signals:
//   adr[AW]  dat_w[DW]  sel[DW/8]  we  cyc  stb  cti[3]  bte[2]   request
//   dat_r[DW]  ack  err  rty                                      response
// -----------------------------------------------------------------------------
interface wb_io_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic [AW-1:0]   adr;
  logic [DW-1:0]   dat_w;
  logic [DW/8-1:0] sel;
  logic            we;
  logic            cyc;
  logic            stb;
  logic [2:0]      cti;
  logic [1:0]      bte;
  logic [DW-1:0]   dat_r;
  logic            ack;
  logic            err;
  logic            rty;

  modport master (
    output adr, dat_w, sel, we, cyc, stb, cti, bte,
    input  dat_r, ack, err, rty
  );

  modport slave (
    input  adr, dat_w, sel, we, cyc, stb, cti, bte,
    output dat_r, ack, err, rty
  );

endinterface

// File: rtl/wb_io_arb_watchdog.sv
// -----------------------------------------------------------------------------
// wb_io_arb_watchdog
// Counts consecutive strobe cycles that receive no slave response and raises
// a one-cycle terminate pulse when the access has hung for TIMEOUT_CYCLES
// strobe cycles. A response arriving in that final cycle wins over the pulse.
// Ports:
//   clk, rst_n    clock / asynchronous active-low reset
//   stb           strobe of the current owner (before any forcing)
//   resp          ack | err | rty from the slave
//   grant_change  arbitration state changes on the next edge
//   timeout       terminate pulse (combinational, this cycle)
// -----------------------------------------------------------------------------
module wb_io_arb_watchdog
  import wb_io_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stb,
  input  logic resp,
  input  logic grant_change,
  output logic timeout
);

  localparam int unsigned       CW       = wd_cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]     LAST_CNT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  // The counter reads LAST_CNT during the TIMEOUT_CYCLES-th strobe cycle.
  assign timeout = stb && !resp && (cnt_q == LAST_CNT);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (grant_change || resp || !stb || timeout) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/wb_io_arbiter.sv
// -----------------------------------------------------------------------------
// wb_io_arbiter
// Two-master round-robin arbiter in front of the IO interconnect's single
// Wishbone master port. Master 0 is the core LSU bridge, master 1 the
// debug/DMA port. Ownership is held for the whole cycle (cyc high), so
// bursts and read-modify-write sequences stay atomic; the owner sees the
// slave's response timing unchanged.
// Optional feature: define WB_IO_ARB_WATCHDOG_EN to add a bus watchdog that
// terminates hung accesses with err after TIMEOUT_CYCLES strobe cycles.
// Ports:
//   wb_clk_i, wb_rst_n_i  bus clock / asynchronous active-low reset
//   wbm0, wbm1            slave modports facing master 0 / master 1
//   wbs                   master modport towards the IO interconnect
//   arb_grant_o[1:0]      one-hot current owner {m1,m0}, 0 when idle
//   arb_timeout_o         one-cycle pulse on watchdog termination
// -----------------------------------------------------------------------------
module wb_io_arbiter
  import wb_io_arb_pkg::*;
#(
  parameter int          AW             = 32,
  parameter int          DW             = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_n_i,
  wb_io_arbiter_if.slave          wbm0,
  wb_io_arbiter_if.slave          wbm1,
  wb_io_arbiter_if.master         wbs,
  output logic [1:0]              arb_grant_o,
  output logic                    arb_timeout_o
);

  arb_state_e state_q, state_d;
  logic       last_owner_q, last_owner_d;   // 0 = m0, 1 = m1
  logic       wd_timeout;

  logic [AW-1:0]   adr_mux;
  logic [DW-1:0]   dat_w_mux;
  logic [DW/8-1:0] sel_mux;
  logic            we_mux;
  logic            cyc_mux;
  logic            stb_mux;
  logic [2:0]      cti_mux;
  logic [1:0]      bte_mux;

  // ---------------------------------------------------------------------------
  // Arbitration FSM. Ownership always passes through IDLE, which gives the
  // one-cycle arbitration latency and guarantees no direct owner-to-owner hop.
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q      <= ST_IDLE;
      last_owner_q <= 1'b1;       // so m0 wins the first tie after reset
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    case (state_q)
      ST_IDLE: begin
        if (wbm0.cyc && wbm1.cyc) begin
          state_d = last_owner_q ? ST_OWN0 : ST_OWN1;
        end else if (wbm0.cyc) begin
          state_d = ST_OWN0;
        end else if (wbm1.cyc) begin
          state_d = ST_OWN1;
        end
      end
      ST_OWN0: begin
        if (!wbm0.cyc) begin
          state_d      = ST_IDLE;
          last_owner_d = 1'b0;
        end
      end
      ST_OWN1: begin
        if (!wbm1.cyc) begin
          state_d      = ST_IDLE;
          last_owner_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request mux: the owner drives the interconnect; idle drives zeros.
  // ---------------------------------------------------------------------------
  always_comb begin
    adr_mux   = '0;
    dat_w_mux = '0;
    sel_mux   = '0;
    we_mux    = 1'b0;
    cyc_mux   = 1'b0;
    stb_mux   = 1'b0;
    cti_mux   = CTI_CLASSIC;
    bte_mux   = 2'b00;
    case (state_q)
      ST_OWN0: begin
        adr_mux   = wbm0.adr;
        dat_w_mux = wbm0.dat_w;
        sel_mux   = wbm0.sel;
        we_mux    = wbm0.we;
        cyc_mux   = wbm0.cyc;
        stb_mux   = wbm0.stb;
        cti_mux   = wbm0.cti;
        bte_mux   = wbm0.bte;
      end
      ST_OWN1: begin
        adr_mux   = wbm1.adr;
        dat_w_mux = wbm1.dat_w;
        sel_mux   = wbm1.sel;
        we_mux    = wbm1.we;
        cyc_mux   = wbm1.cyc;
        stb_mux   = wbm1.stb;
        cti_mux   = wbm1.cti;
        bte_mux   = wbm1.bte;
      end
      default: ;
    endcase
  end

  assign wbs.adr   = adr_mux;
  assign wbs.dat_w = dat_w_mux;
  assign wbs.sel   = sel_mux;
  assign wbs.we    = we_mux;
  assign wbs.cti   = cti_mux;
  assign wbs.bte   = bte_mux;
  // A watchdog termination withdraws the access from the slave in the same
  // cycle the owner is handed its err.
  assign wbs.cyc   = cyc_mux && !wd_timeout;
  assign wbs.stb   = stb_mux && !wd_timeout;

  // ---------------------------------------------------------------------------
  // Response routing: only the owner sees slave data and terminations.
  // ---------------------------------------------------------------------------
  assign wbm0.dat_r = (state_q == ST_OWN0) ? wbs.dat_r : '0;
  assign wbm0.ack   = (state_q == ST_OWN0) && wbs.ack;
  assign wbm0.err   = (state_q == ST_OWN0) && (wbs.err || wd_timeout);
  assign wbm0.rty   = (state_q == ST_OWN0) && wbs.rty;

  assign wbm1.dat_r = (state_q == ST_OWN1) ? wbs.dat_r : '0;
  assign wbm1.ack   = (state_q == ST_OWN1) && wbs.ack;
  assign wbm1.err   = (state_q == ST_OWN1) && (wbs.err || wd_timeout);
  assign wbm1.rty   = (state_q == ST_OWN1) && wbs.rty;

  assign arb_grant_o   = state_q;     // encoding doubles as {m1,m0} grant
  assign arb_timeout_o = wd_timeout;

  // ---------------------------------------------------------------------------
  // Optional bus watchdog.
  // ---------------------------------------------------------------------------
`ifdef WB_IO_ARB_WATCHDOG_EN
  wb_io_arb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk          (wb_clk_i),
    .rst_n        (wb_rst_n_i),
    .stb          (stb_mux),
    .resp         (wbs.ack || wbs.err || wbs.rty),
    .grant_change (state_d != state_q),
    .timeout      (wd_timeout)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign wd_timeout         = 1'b0;
`endif

endmodule
